// File: rtl/aes_encrypt_ctrl.sv
// Round sequencer for AES-128 encryption around a single-round core.
// It performs the initial AddRoundKey, iterates rounds 0..9, then holds the ciphertext until it is accepted.
module aes_encrypt_ctrl (
  input  logic         clock,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         busy,
  output logic         core_enable,
  output logic [127:0] core_text,
  output logic [127:0] core_key,
  output logic [3:0]   core_round,
  input  logic [127:0] core_text_out,
  input  logic [127:0] core_key_out,
  input  logic         core_done
);

  typedef enum logic [1:0] {IDLE, RUN, GAP, OUT} fsm_e;

  localparam logic [3:0] LastRound = 4'd9;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] out_q, out_d;
  logic [3:0]   round_q, round_d;

  // Reset discards any block in flight and clears every visible register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      out_q   <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      out_q   <= out_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    out_d   = out_q;
    round_d = round_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_text ^ in_key;
          key_d   = in_key;
          round_d = '0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        if (core_done) begin
          state_d = core_text_out;
          key_d   = core_key_out;
          if (round_q == LastRound) begin
            out_d = core_text_out;
            fsm_d = OUT;
          end else begin
            round_d = round_q + 4'd1;
            fsm_d   = GAP;
          end
        end
      end
      // The core still shows the previous round's done here, so it is not sampled.
      GAP: begin
        fsm_d = RUN;
      end
      OUT: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  assign in_ready    = (fsm_q == IDLE);
  assign out_valid   = (fsm_q == OUT);
  assign busy        = (fsm_q == RUN) || (fsm_q == GAP);
  assign core_enable = (fsm_q == RUN);
  assign core_text   = state_q;
  assign core_key    = key_q;
  assign core_round  = round_q;
  assign out_text    = out_q;

endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// Testbench for aes_encrypt_ctrl.
// It includes a behavioural single-round AES core with a 20-cycle done latency, plus an extra done input for injecting spurious pulses.
module tb_aes_encrypt_ctrl;

  localparam logic [127:0] FipsKey = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] FipsPt  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] FipsCt  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] ZeroCt  = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

  logic         clock;
  logic         resetn;
  logic         inValid;
  logic         inReady;
  logic [127:0] inText;
  logic [127:0] inKey;
  logic         outValid;
  logic         outReady;
  logic [127:0] outText;
  logic         busy;
  logic         coreEnable;
  logic [127:0] coreText;
  logic [127:0] coreKey;
  logic [3:0]   coreRound;
  logic [127:0] coreTextOut;
  logic [127:0] coreKeyOut;
  logic         coreDone;
  logic         extraDone;
  int           coreCnt;

  int checkCount = 0;
  int passCount  = 0;

  aes_encrypt_ctrl dut (
    .clock         (clock),
    .resetn        (resetn),
    .in_valid      (inValid),
    .in_ready      (inReady),
    .in_text       (inText),
    .in_key        (inKey),
    .out_valid     (outValid),
    .out_ready     (outReady),
    .out_text      (outText),
    .busy          (busy),
    .core_enable   (coreEnable),
    .core_text     (coreText),
    .core_key      (coreKey),
    .core_round    (coreRound),
    .core_text_out (coreTextOut),
    .core_key_out  (coreKeyOut),
    .core_done     (coreDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // GF(2^8) arithmetic used by the behavioural round model.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, b);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < int'(rnd); i++) r = xtime(r);
    return r;
  endfunction

  function automatic logic [127:0] nextKey(input logic [127:0] k, input logic [3:0] rnd);
    logic [31:0]  w [4];
    logic [31:0]  t;
    logic [127:0] nk;
    for (int j = 0; j < 4; j++) w[j] = k[32*j +: 32];
    t = {w[3][7:0], w[3][31:24], w[3][23:16], w[3][15:8]};
    for (int j = 0; j < 4; j++) t[8*j +: 8] = sbox(t[8*j +: 8]);
    t[7:0] = t[7:0] ^ rcon(rnd);
    w[0] = w[0] ^ t;
    w[1] = w[1] ^ w[0];
    w[2] = w[2] ^ w[1];
    w[3] = w[3] ^ w[2];
    for (int j = 0; j < 4; j++) nk[32*j +: 32] = w[j];
    return nk;
  endfunction

  function automatic logic [127:0] roundOut(input logic [127:0] s, input logic [127:0] k,
                                            input logic [3:0] rnd);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   m0, m1, m2, m3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        b[row + 4*c] = a[row + 4*((c + row) % 4)];
    if (rnd != 4'd9) begin
      for (int c = 0; c < 4; c++) begin
        m0 = b[4*c]; m1 = b[4*c+1]; m2 = b[4*c+2]; m3 = b[4*c+3];
        b[4*c]   = xtime(m0) ^ gmul(m1, 8'h03) ^ m2 ^ m3;
        b[4*c+1] = m0 ^ xtime(m1) ^ gmul(m2, 8'h03) ^ m3;
        b[4*c+2] = m0 ^ m1 ^ xtime(m2) ^ gmul(m3, 8'h03);
        b[4*c+3] = gmul(m0, 8'h03) ^ m1 ^ m2 ^ xtime(m3);
      end
    end
    for (int i = 0; i < 16; i++) r[8*i +: 8] = b[i];
    return r ^ nextKey(k, rnd);
  endfunction

  // Core model: counter clears whenever enable is low; done stays high from count 20 on.
  always @(posedge clock) begin
    if (coreEnable) coreCnt <= coreCnt + 1;
    else            coreCnt <= 0;
  end

  assign coreDone    = (coreCnt >= 20) || extraDone;
  assign coreKeyOut  = nextKey(coreKey, coreRound);
  assign coreTextOut = roundOut(coreText, coreKey, coreRound);

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic offerBlock(input logic [127:0] pt, input logic [127:0] key);
    @(negedge clock);
    inText  = pt;
    inKey   = key;
    inValid = 1'b1;
    @(posedge clock);
    #1;
    inValid = 1'b0;
  endtask

  task automatic waitOutput(output int cycles);
    cycles = 0;
    while (outValid !== 1'b1 && cycles < 400) begin
      @(posedge clock);
      #1;
      cycles++;
    end
  endtask

  task automatic releaseOutput();
    @(negedge clock);
    outReady = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkCount++;
    if (inReady !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", inReady);
    else passCount++;
    checkCount++;
    if (outValid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid);
    else passCount++;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    else passCount++;
    checkCount++;
    if (coreEnable !== 1'b0) $display("[TB] FAIL reset_core_enable: got %b expected 0", coreEnable);
    else passCount++;
    checkCount++;
    if (coreText !== 128'h0) $display("[TB] FAIL reset_core_text: got %h expected 0", coreText);
    else passCount++;
    checkCount++;
    if (coreKey !== 128'h0) $display("[TB] FAIL reset_core_key: got %h expected 0", coreKey);
    else passCount++;
    checkCount++;
    if (coreRound !== 4'd0) $display("[TB] FAIL reset_core_round: got %0d expected 0", coreRound);
    else passCount++;
    checkCount++;
    if (outText !== 128'h0) $display("[TB] FAIL reset_out_text: got %h expected 0", outText);
    else passCount++;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_fips();
    int cycles;
    offerBlock(FipsPt, FipsKey);
    checkCount++;
    if (coreText !== (FipsPt ^ FipsKey))
      $display("[TB] FAIL fips_initial_addkey: got %h expected %h", coreText, FipsPt ^ FipsKey);
    else passCount++;
    checkCount++;
    if (coreKey !== FipsKey) $display("[TB] FAIL fips_initial_key: got %h expected %h", coreKey, FipsKey);
    else passCount++;
    checkCount++;
    if (busy !== 1'b1 || inReady !== 1'b0)
      $display("[TB] FAIL fips_accept: got busy=%b in_ready=%b expected busy=1 in_ready=0", busy, inReady);
    else passCount++;
    waitOutput(cycles);
    checkCount++;
    if (cycles != 219) $display("[TB] FAIL fips_latency: got %0d expected 219", cycles);
    else passCount++;
    checkCount++;
    if (outText !== FipsCt) $display("[TB] FAIL fips_ciphertext: got %h expected %h", outText, FipsCt);
    else passCount++;
    releaseOutput();
    checkCount++;
    if (inReady !== 1'b1 || outValid !== 1'b0)
      $display("[TB] FAIL fips_handshake: got in_ready=%b out_valid=%b expected 1 and 0", inReady, outValid);
    else passCount++;
  endtask

  task automatic test_zero_rounds();
    int cycles, rises, roundErrs, gapErrs, gapCycles, lowLen, holdErrs;
    logic prevEn;
    logic [127:0] heldText, heldKey;
    offerBlock(128'h0, 128'h0);
    cycles = 0; rises = 0; roundErrs = 0; gapErrs = 0; gapCycles = 0; lowLen = 0; holdErrs = 0;
    prevEn = 1'b0; heldText = '0; heldKey = '0;
    while (outValid !== 1'b1 && cycles < 400) begin
      if (coreEnable === 1'b1) begin
        if (prevEn == 1'b0) begin
          if (coreRound !== 4'(rises)) roundErrs++;
          if (rises != 0 && lowLen != 1) gapErrs++;
          rises++;
          lowLen   = 0;
          heldText = coreText;
          heldKey  = coreKey;
        end else if (coreText !== heldText || coreKey !== heldKey) begin
          holdErrs++;
        end
      end else if (busy === 1'b1) begin
        lowLen++;
        gapCycles++;
      end
      prevEn = coreEnable;
      @(posedge clock);
      #1;
      cycles++;
    end
    checkCount++;
    if (rises != 10) $display("[TB] FAIL zero_round_count: got %0d expected 10", rises);
    else passCount++;
    checkCount++;
    if (roundErrs != 0) $display("[TB] FAIL zero_round_sequence: got %0d out-of-order rounds expected 0", roundErrs);
    else passCount++;
    checkCount++;
    if (gapErrs != 0 || gapCycles != 9)
      $display("[TB] FAIL zero_gap_cycles: got %0d gap cycles (%0d bad gaps) expected 9 (0)", gapCycles, gapErrs);
    else passCount++;
    checkCount++;
    if (holdErrs != 0) $display("[TB] FAIL zero_core_inputs_held: got %0d changes expected 0", holdErrs);
    else passCount++;
    checkCount++;
    if (cycles != 219) $display("[TB] FAIL zero_latency: got %0d expected 219", cycles);
    else passCount++;
    checkCount++;
    if (outText !== ZeroCt) $display("[TB] FAIL zero_ciphertext: got %h expected %h", outText, ZeroCt);
    else passCount++;
    releaseOutput();
  endtask

  task automatic test_backpressure();
    int cycles, holdErrs, idleErrs;
    offerBlock(FipsPt, FipsKey);
    waitOutput(cycles);
    holdErrs = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        @(negedge clock);
        inText  = 128'h0;
        inKey   = 128'h0;
        inValid = 1'b1;
      end
      @(posedge clock);
      #1;
      inValid = 1'b0;
      if (outValid !== 1'b1 || outText !== FipsCt || inReady !== 1'b0) holdErrs++;
    end
    checkCount++;
    if (holdErrs != 0) $display("[TB] FAIL bp_hold_stable: got %0d unstable cycles expected 0", holdErrs);
    else passCount++;
    checkCount++;
    if (coreText !== FipsCt || busy !== 1'b0)
      $display("[TB] FAIL bp_ignored_offer: got core_text=%h busy=%b expected %h and 0", coreText, busy, FipsCt);
    else passCount++;
    releaseOutput();
    idleErrs = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (inReady !== 1'b1 || busy !== 1'b0) idleErrs++;
    end
    checkCount++;
    if (idleErrs != 0) $display("[TB] FAIL bp_no_auto_accept: got %0d busy cycles expected 0", idleErrs);
    else passCount++;
    offerBlock(128'h0, 128'h0);
    waitOutput(cycles);
    checkCount++;
    if (outText !== ZeroCt) $display("[TB] FAIL bp_reoffer_ciphertext: got %h expected %h", outText, ZeroCt);
    else passCount++;
    releaseOutput();
  endtask

  task automatic test_spurious_done();
    int cycles, gapPulses;
    logic [3:0]   r0;
    logic [127:0] t0;
    r0 = coreRound;
    t0 = coreText;
    @(negedge clock);
    extraDone = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkCount++;
    if (busy !== 1'b0 || inReady !== 1'b1 || outValid !== 1'b0 || coreRound !== r0 || coreText !== t0)
      $display("[TB] FAIL idle_done_ignored: got busy=%b round=%0d text=%h expected busy=0 round=%0d text=%h",
               busy, coreRound, coreText, r0, t0);
    else passCount++;
    @(negedge clock);
    extraDone = 1'b0;
    offerBlock(FipsPt, FipsKey);
    cycles = 0;
    gapPulses = 0;
    while (outValid !== 1'b1 && cycles < 400) begin
      @(posedge clock);
      #1;
      cycles++;
      if (busy === 1'b1 && coreEnable === 1'b0) begin
        extraDone = 1'b1;
        gapPulses++;
        @(negedge clock);
        extraDone = 1'b0;
      end
    end
    checkCount++;
    if (gapPulses != 9) $display("[TB] FAIL gap_done_count: got %0d gap cycles expected 9", gapPulses);
    else passCount++;
    checkCount++;
    if (cycles != 219) $display("[TB] FAIL gap_done_latency: got %0d expected 219", cycles);
    else passCount++;
    checkCount++;
    if (outText !== FipsCt) $display("[TB] FAIL gap_done_ciphertext: got %h expected %h", outText, FipsCt);
    else passCount++;
    @(negedge clock);
    extraDone = 1'b1;
    @(posedge clock);
    #1;
    extraDone = 1'b0;
    checkCount++;
    if (outValid !== 1'b1 || outText !== FipsCt)
      $display("[TB] FAIL out_done_ignored: got valid=%b text=%h expected 1 and %h", outValid, outText, FipsCt);
    else passCount++;
    releaseOutput();
  endtask

  task automatic test_reset_midop();
    int guard, cycles;
    offerBlock(FipsPt, FipsKey);
    guard = 0;
    while (!(coreRound === 4'd4 && coreEnable === 1'b1) && guard < 300) begin
      @(posedge clock);
      #1;
      guard++;
    end
    checkCount++;
    if (coreRound !== 4'd4) $display("[TB] FAIL midop_reach_round4: got %0d expected 4", coreRound);
    else passCount++;
    repeat (5) @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    checkCount++;
    if (inReady !== 1'b1 || outValid !== 1'b0 || busy !== 1'b0 || coreEnable !== 1'b0)
      $display("[TB] FAIL midop_async_ctrl: got in_ready=%b out_valid=%b busy=%b enable=%b expected 1 0 0 0",
               inReady, outValid, busy, coreEnable);
    else passCount++;
    checkCount++;
    if (coreText !== 128'h0 || coreKey !== 128'h0 || coreRound !== 4'd0 || outText !== 128'h0)
      $display("[TB] FAIL midop_async_data: got text=%h key=%h round=%0d out=%h expected all zero",
               coreText, coreKey, coreRound, outText);
    else passCount++;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    offerBlock(FipsPt, FipsKey);
    waitOutput(cycles);
    checkCount++;
    if (cycles != 219 || outText !== FipsCt)
      $display("[TB] FAIL midop_fresh_block: got latency=%0d text=%h expected 219 and %h", cycles, outText, FipsCt);
    else passCount++;
    releaseOutput();
  endtask

  task automatic test_back_to_back();
    int cycles;
    outReady = 1'b1;
    @(negedge clock);
    inText  = 128'h0;
    inKey   = 128'h0;
    inValid = 1'b1;
    @(posedge clock);
    #1;
    inText = FipsPt;
    inKey  = FipsKey;
    checkCount++;
    if (busy !== 1'b1) $display("[TB] FAIL b2b_first_accept: got busy=%b expected 1", busy);
    else passCount++;
    waitOutput(cycles);
    checkCount++;
    if (cycles != 219 || outText !== ZeroCt)
      $display("[TB] FAIL b2b_first_block: got latency=%0d text=%h expected 219 and %h", cycles, outText, ZeroCt);
    else passCount++;
    @(posedge clock);
    #1;
    checkCount++;
    if (inReady !== 1'b1 || outValid !== 1'b0)
      $display("[TB] FAIL b2b_handshake_idle: got in_ready=%b out_valid=%b expected 1 and 0", inReady, outValid);
    else passCount++;
    @(posedge clock);
    #1;
    inValid = 1'b0;
    checkCount++;
    if (busy !== 1'b1 || coreText !== (FipsPt ^ FipsKey))
      $display("[TB] FAIL b2b_second_accept: got busy=%b text=%h expected 1 and %h", busy, coreText, FipsPt ^ FipsKey);
    else passCount++;
    waitOutput(cycles);
    checkCount++;
    if (cycles != 219 || outText !== FipsCt)
      $display("[TB] FAIL b2b_second_block: got latency=%0d text=%h expected 219 and %h", cycles, outText, FipsCt);
    else passCount++;
    @(posedge clock);
    #1;
    outReady = 1'b0;
    checkCount++;
    if (inReady !== 1'b1) $display("[TB] FAIL b2b_final_idle: got in_ready=%b expected 1", inReady);
    else passCount++;
  endtask

  initial begin
    resetn    = 1'b0;
    inValid   = 1'b0;
    inText    = '0;
    inKey     = '0;
    outReady  = 1'b0;
    extraDone = 1'b0;
    test_reset();
    test_fips();
    test_zero_rounds();
    test_backpressure();
    test_spurious_done();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
